// File: rtl/cu_fsm_if.sv
// Control-unit bus: instruction/interrupt inputs toward the FSM and the enables it
// drives into the datapath. The state code and pending-interrupt flag are carried
// alongside so that checkers can observe the FSM.
interface cu_fsm_if;
    logic       intr;
    logic       mie;
    logic [6:0] opcode;
    logic [2:0] func3;

    logic       pcWrite;
    logic       regWrite;
    logic       memWE2;
    logic       memRDEN1;
    logic       memRDEN2;
    logic       reset;
    logic       csr_WE;
    logic       int_taken;
    logic       mret_exec;

    logic [2:0] state;
    logic       intr_pend;

    // Control unit side
    modport master (
        input  intr, mie, opcode, func3,
        output pcWrite, regWrite, memWE2, memRDEN1, memRDEN2, reset,
               csr_WE, int_taken, mret_exec, state, intr_pend
    );

    // Datapath / CSR side
    modport slave (
        output intr, mie, opcode, func3,
        input  pcWrite, regWrite, memWE2, memRDEN1, memRDEN2, reset,
               csr_WE, int_taken, mret_exec, state, intr_pend
    );
endinterface

// File: rtl/cu_fsm.sv
// Multicycle OTTER control unit: FETCH -> EXEC [-> WB] [-> INTR] -> FETCH.
// Outputs are decoded combinationally from the current state (and from
// opcode/func3 while in EXEC), so enables line up with the cycle they belong to.
module cu_fsm (
    input  logic      CLK,
    input  logic      RST,
    cu_fsm_if.master  bus
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_RG3    = 7'b0110011;
    localparam logic [6:0] OP_SYS    = 7'b1110011;

    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_FETCH = 3'd1,
        ST_EXEC  = 3'd2,
        ST_WB    = 3'd3,
        ST_INTR  = 3'd4
    } state_t;

    state_t state;
    logic   intr_pend;
    logic   is_load;
    logic   take_int;
    logic   enter_intr;

    assign is_load  = (bus.opcode == OP_LOAD);
    // A request is honoured if it is pending or arriving now, gated by this cycle's mie.
    assign take_int = (intr_pend | bus.intr) & bus.mie;
    // Instruction boundaries: end of a non-load EXEC, or end of WB. Loads are never split.
    assign enter_intr = take_int &
                        (((state == ST_EXEC) & ~is_load) | (state == ST_WB));

    // State register and pending-interrupt flop; clearing on INTR entry beats a
    // coincident request, but a request seen during INTR itself re-arms the flop.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= ST_INIT;
            intr_pend <= 1'b0;
        end else begin
            case (state)
                ST_INIT:  state <= ST_FETCH;
                ST_FETCH: state <= ST_EXEC;
                ST_EXEC:  begin
                    if (is_load)       state <= ST_WB;
                    else if (take_int) state <= ST_INTR;
                    else               state <= ST_FETCH;
                end
                ST_WB:    state <= take_int ? ST_INTR : ST_FETCH;
                ST_INTR:  state <= ST_FETCH;
                default:  state <= ST_INIT;
            endcase

            if (enter_intr)    intr_pend <= 1'b0;
            else if (bus.intr) intr_pend <= 1'b1;
        end
    end

    // Output decode from current state and, in EXEC, the instruction class.
    always_comb begin
        bus.pcWrite   = 1'b0;
        bus.regWrite  = 1'b0;
        bus.memWE2    = 1'b0;
        bus.memRDEN1  = 1'b0;
        bus.memRDEN2  = 1'b0;
        bus.reset     = 1'b0;
        bus.csr_WE    = 1'b0;
        bus.int_taken = 1'b0;
        bus.mret_exec = 1'b0;
        case (state)
            ST_INIT:  bus.reset    = 1'b1;
            ST_FETCH: bus.memRDEN1 = 1'b1;
            ST_EXEC: begin
                case (bus.opcode)
                    OP_LOAD:  bus.memRDEN2 = 1'b1;
                    OP_STORE: begin
                        bus.memWE2  = 1'b1;
                        bus.pcWrite = 1'b1;
                    end
                    OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_IMM, OP_RG3: begin
                        bus.regWrite = 1'b1;
                        bus.pcWrite  = 1'b1;
                    end
                    OP_SYS: begin
                        bus.pcWrite = 1'b1;
                        if (bus.func3 == 3'b000) begin
                            bus.mret_exec = 1'b1;
                        end else if (bus.func3 == 3'b001) begin
                            bus.csr_WE   = 1'b1;
                            bus.regWrite = 1'b1;
                        end
                    end
                    // BRANCH and unrecognised opcodes only advance the PC.
                    default:  bus.pcWrite = 1'b1;
                endcase
            end
            ST_WB: begin
                bus.regWrite = 1'b1;
                bus.pcWrite  = 1'b1;
            end
            ST_INTR: begin
                bus.int_taken = 1'b1;
                bus.pcWrite   = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.state     = state;
    assign bus.intr_pend = intr_pend;

endmodule

// File: tb/tb_cu_fsm.sv
// Directed bench for cu_fsm: walks reset, each instruction class, interrupt entry,
// masking, MRET/CSRRW and reset mid-instruction, checking state and all enables.
module tb_cu_fsm;

    // Expected state codes
    localparam logic [2:0] S_INIT  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_EXEC  = 3'd2;
    localparam logic [2:0] S_WB    = 3'd3;
    localparam logic [2:0] S_INTR  = 3'd4;

    // {pcWrite,regWrite,memWE2,memRDEN1,memRDEN2,reset,csr_WE,int_taken,mret_exec}
    localparam logic [8:0] O_INIT    = 9'b000001000;
    localparam logic [8:0] O_FETCH   = 9'b000100000;
    localparam logic [8:0] O_ALU     = 9'b110000000;
    localparam logic [8:0] O_LOAD_EX = 9'b000010000;
    localparam logic [8:0] O_WB      = 9'b110000000;
    localparam logic [8:0] O_STORE   = 9'b101000000;
    localparam logic [8:0] O_PC      = 9'b100000000;
    localparam logic [8:0] O_INTR    = 9'b100000010;
    localparam logic [8:0] O_MRET    = 9'b100000001;
    localparam logic [8:0] O_CSRRW   = 9'b110000100;

    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] OPIMM  = 7'b0010011;
    localparam logic [6:0] SYS    = 7'b1110011;
    localparam logic [6:0] FENCE  = 7'b0001111;

    logic CLK;
    logic RST;
    int   checks;
    int   passes;
    int   fails;
    logic [6:0] alu_ops [5];

    cu_fsm_if bus ();

    cu_fsm dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    // Clock
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [8:0] outs();
        return {bus.pcWrite, bus.regWrite, bus.memWE2, bus.memRDEN1, bus.memRDEN2,
                bus.reset, bus.csr_WE, bus.int_taken, bus.mret_exec};
    endfunction

    // Advance one clock edge and settle away from it
    task automatic cyc();
        @(posedge CLK);
        #2;
    endtask

    task automatic check(input string tag, input logic [2:0] st, input logic [8:0] o);
        #1;
        checks++;
        assert (bus.state === st) passes++;
        else begin
            fails++;
            $error("FAIL %s state: got %0d expected %0d", tag, bus.state, st);
        end
        checks++;
        assert (outs() === o) passes++;
        else begin
            fails++;
            $error("FAIL %s outs: got %b expected %b", tag, outs(), o);
        end
    endtask

    task automatic check_pend(input string tag, input logic p);
        #1;
        checks++;
        assert (bus.intr_pend === p) passes++;
        else begin
            fails++;
            $error("FAIL %s intr_pend: got %b expected %b", tag, bus.intr_pend, p);
        end
    endtask

    initial begin
        checks = 0;
        passes = 0;
        fails  = 0;
        alu_ops[0] = 7'b0110111;
        alu_ops[1] = 7'b0010111;
        alu_ops[2] = 7'b1101111;
        alu_ops[3] = 7'b1100111;
        alu_ops[4] = 7'b0110011;

        RST = 1'b1;
        bus.intr = 1'b0;
        bus.mie = 1'b0;
        bus.opcode = 7'd0;
        bus.func3 = 3'd0;

        // Reset then OP_IMM
        cyc(); cyc();
        check("rst", S_INIT, O_INIT);
        check_pend("rst", 1'b0);
        RST = 1'b0;
        bus.opcode = OPIMM;
        cyc(); check("alu_fetch", S_FETCH, O_FETCH);
        cyc(); check("alu_exec", S_EXEC, O_ALU);
        cyc(); check("alu_period", S_FETCH, O_FETCH);

        // LOAD: 3 cycles
        bus.opcode = LOAD;
        cyc(); check("ld_exec", S_EXEC, O_LOAD_EX);
        cyc(); check("ld_wb", S_WB, O_WB);
        cyc(); check("ld_done", S_FETCH, O_FETCH);

        // STORE, BRANCH, unknown opcode
        bus.opcode = STORE;
        cyc(); check("st_exec", S_EXEC, O_STORE);
        cyc(); check("st_done", S_FETCH, O_FETCH);
        bus.opcode = BRANCH;
        cyc(); check("br_exec", S_EXEC, O_PC);
        cyc(); check("br_done", S_FETCH, O_FETCH);
        bus.opcode = FENCE;
        cyc(); check("nop_exec", S_EXEC, O_PC);
        cyc(); check("nop_done", S_FETCH, O_FETCH);

        // Remaining register-writing classes
        for (int i = 0; i < 5; i++) begin
            bus.opcode = alu_ops[i];
            cyc(); check($sformatf("rw_exec%0d", i), S_EXEC, O_ALU);
            cyc(); check($sformatf("rw_done%0d", i), S_FETCH, O_FETCH);
        end

        // Interrupt pulse in FETCH with mie=1
        bus.opcode = OPIMM;
        bus.mie = 1'b1;
        bus.intr = 1'b1;
        check("ip_fetch", S_FETCH, O_FETCH);
        cyc(); bus.intr = 1'b0;
        check("ip_exec", S_EXEC, O_ALU);
        check_pend("ip_exec", 1'b1);
        cyc(); check("ip_intr", S_INTR, O_INTR);
        check_pend("ip_intr", 1'b0);
        cyc(); check("ip_after", S_FETCH, O_FETCH);
        check_pend("ip_after", 1'b0);

        // Masked interrupt held pending across three instructions
        bus.mie = 1'b0;
        bus.intr = 1'b1;
        cyc(); bus.intr = 1'b0;
        check("mk_exec0", S_EXEC, O_ALU);
        check_pend("mk_exec0", 1'b1);
        cyc(); check("mk_bound0", S_FETCH, O_FETCH);
        for (int i = 1; i < 3; i++) begin
            cyc(); check($sformatf("mk_exec%0d", i), S_EXEC, O_ALU);
            cyc(); check($sformatf("mk_bound%0d", i), S_FETCH, O_FETCH);
        end
        check_pend("mk_held", 1'b1);
        bus.mie = 1'b1;
        cyc(); check("mk_exec3", S_EXEC, O_ALU);
        cyc(); check("mk_taken", S_INTR, O_INTR);
        cyc(); check("mk_after", S_FETCH, O_FETCH);

        // Worst-case latency: request in FETCH of a load
        bus.opcode = LOAD;
        bus.intr = 1'b1;
        cyc(); bus.intr = 1'b0;
        check("lat_exec", S_EXEC, O_LOAD_EX);
        cyc(); check("lat_wb", S_WB, O_WB);
        cyc(); check("lat_intr", S_INTR, O_INTR);
        cyc(); check("lat_after", S_FETCH, O_FETCH);

        // Clear beats set on INTR entry; a request during INTR re-arms
        bus.opcode = OPIMM;
        cyc(); bus.intr = 1'b1;
        check("sc_exec", S_EXEC, O_ALU);
        cyc(); check("sc_intr", S_INTR, O_INTR);
        check_pend("sc_clear_wins", 1'b0);
        cyc(); bus.intr = 1'b0;
        check("sc_fetch", S_FETCH, O_FETCH);
        check_pend("sc_rearm", 1'b1);
        cyc(); check("sc_exec2", S_EXEC, O_ALU);
        cyc(); check("sc_intr2", S_INTR, O_INTR);
        check_pend("sc_intr2", 1'b0);
        cyc(); check("sc_after", S_FETCH, O_FETCH);

        // MRET with a pending interrupt: MRET first, then INTR
        bus.opcode = SYS;
        bus.func3 = 3'b000;
        bus.intr = 1'b1;
        cyc(); bus.intr = 1'b0;
        check("mret_exec", S_EXEC, O_MRET);
        cyc(); check("mret_intr", S_INTR, O_INTR);
        cyc(); check("mret_after", S_FETCH, O_FETCH);

        // CSRRW and other SYS func3
        bus.mie = 1'b0;
        bus.func3 = 3'b001;
        cyc(); check("csrrw_exec", S_EXEC, O_CSRRW);
        cyc(); check("csrrw_done", S_FETCH, O_FETCH);
        bus.func3 = 3'b010;
        cyc(); check("sys_other", S_EXEC, O_PC);
        cyc(); check("sys_done", S_FETCH, O_FETCH);

        // Reset during WB, with intr high
        bus.opcode = LOAD;
        cyc(); check("rw_ld_exec", S_EXEC, O_LOAD_EX);
        cyc(); check("rw_ld_wb", S_WB, O_WB);
        RST = 1'b1;
        bus.intr = 1'b1;
        cyc(); check("rst_wb", S_INIT, O_INIT);
        check_pend("rst_wb", 1'b0);
        RST = 1'b0;
        bus.intr = 1'b0;
        cyc(); check("rst_wb_fetch", S_FETCH, O_FETCH);

        // Reset during INTR
        bus.opcode = OPIMM;
        bus.mie = 1'b1;
        bus.intr = 1'b1;
        cyc(); bus.intr = 1'b0;
        check("ri_exec", S_EXEC, O_ALU);
        cyc(); check("ri_intr", S_INTR, O_INTR);
        RST = 1'b1;
        cyc(); check("rst_intr", S_INIT, O_INIT);
        RST = 1'b0;
        cyc(); check("rst_intr_fetch", S_FETCH, O_FETCH);
        check_pend("rst_intr_fetch", 1'b0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/cu_fsm.md
# cu_fsm

Multicycle control-unit state machine for the OTTER RV32I core. It sequences each instruction through fetch, execute, optional load writeback, and interrupt entry. It drives the write and read enables for the PC, register file, memory and CSR file. It also produces `int_taken`, which the companion decoder uses to select MTVEC as the next PC.

## Interface
- No parameters.
- `CLK` in 1: system clock; all state changes on rising edge.
- `RST` in 1: synchronous, active-high reset.
- `intr` in 1: external interrupt request (level or single-cycle pulse).
- `mie` in 1: global machine interrupt enable (mstatus.MIE from CSR file).
- `opcode` in 7: ir[6:0].
- `func3` in 3: ir[14:12].
- `pcWrite` out 1: PC register load enable.
- `regWrite` out 1: register file write enable.
- `memWE2` out 1: data-port write enable.
- `memRDEN1` out 1: instruction-port read enable.
- `memRDEN2` out 1: data-port read enable.
- `reset` out 1: PC/datapath reset strobe.
- `csr_WE` out 1: CSR file write enable.
- `int_taken` out 1: interrupt entry in progress (to decoder and CSR file).
- `mret_exec` out 1: MRET executing (CSR file restores MIE).

## Operation
- States: `ST_INIT`, `ST_FETCH`, `ST_EXEC`, `ST_WB`, `ST_INTR`. State is 3-bit encoded. Illegal encodings go to `ST_INIT`.
- All outputs default to 0 in every state unless listed below.
- `ST_INIT`:
  - `reset`=1.
  - Next state: `ST_FETCH`.
- `ST_FETCH`:
  - `memRDEN1`=1.
  - Next state: `ST_EXEC`.
- `ST_EXEC` outputs, decoded from `opcode`/`func3`:
  - LOAD (0000011): `memRDEN2`=1, `pcWrite`=0. Next state: `ST_WB`.
  - STORE (0100011): `memWE2`=1, `pcWrite`=1.
  - BRANCH (1100011): `pcWrite`=1.
  - LUI, AUIPC, JAL, JALR, OP_IMM, OP_RG3: `regWrite`=1, `pcWrite`=1.
  - SYS (1110011) with func3=000 (MRET): `pcWrite`=1, `mret_exec`=1.
  - SYS with func3=001 (CSRRW): `csr_WE`=1, `regWrite`=1, `pcWrite`=1.
  - SYS with any other func3: `pcWrite`=1 only.
  - Any other opcode: `pcWrite`=1 only (executes as a NOP; no register, memory or CSR write).
- `ST_WB`:
  - `regWrite`=1, `pcWrite`=1.
- `ST_INTR`:
  - `int_taken`=1, `pcWrite`=1.
  - Next state: `ST_FETCH`.
- Pending-interrupt flop `intr_pend`:
  - Set on any cycle with `intr`=1.
  - Cleared on the clock edge that enters `ST_INTR`, and by `RST`.
  - If set and clear occur in the same cycle, set wins only when `intr`=1 during `ST_INTR` itself.
- Interrupt decision, taken on leaving `ST_EXEC` (non-load) or `ST_WB`:
  - If `(intr_pend | intr) & mie`, next state is `ST_INTR`.
  - Otherwise next state is `ST_FETCH`.
  - The decision uses the `mie` value present in that cycle.
- An interrupt never splits a LOAD. It is evaluated only after `ST_WB`.
- A pending interrupt with `mie`=0 stays pending. It is taken at the first instruction boundary where `mie`=1.

## Timing
- Reset:
  - `RST`=1 sampled on an edge puts the FSM in `ST_INIT`, regardless of current state (including mid-LOAD or `ST_INTR`) and regardless of `intr`.
  - `intr_pend` is cleared to 0.
  - Outputs during `ST_INIT` cycles: `reset`=1, all others 0.
- Cycles per instruction:
  - 2 (FETCH, EXEC) for non-load instructions.
  - 3 (FETCH, EXEC, WB) for loads.
  - +1 when an interrupt is taken (INTR).
- Output behaviour:
  - Outputs are combinational from the current state, plus `opcode`/`func3` in `ST_EXEC`.
  - No registered output delay.
  - `pcWrite` is asserted exactly once per instruction, and once per interrupt entry.
- Interrupt latency: at most 3 cycles from `intr` assertion to `int_taken` (worst case: asserted in FETCH of a load).
- MRET with a pending interrupt and `mie`=1 in the same EXEC cycle: MRET completes first (`mret_exec` pulse), then `ST_INTR` follows immediately.

## Test plan
- Reset and ALU op:
  - Stimulus: `RST`=1 for 2 cycles, release, opcode=0010011.
  - Required: `reset`=1 while in INIT; then FETCH with `memRDEN1`=1; then EXEC with `regWrite`=`pcWrite`=1; then back to FETCH. Period is 2 cycles.
- LOAD sequence:
  - Stimulus: opcode=0000011.
  - Required: EXEC gives `memRDEN2`=1, `pcWrite`=0; WB gives `regWrite`=`pcWrite`=1; 3-cycle instruction.
- STORE and BRANCH:
  - STORE required: `memWE2`=1, `regWrite`=0.
  - BRANCH required: only `pcWrite`=1.
- Interrupt pulse:
  - Stimulus: 1-cycle `intr` pulse during FETCH, `mie`=1.
  - Required: after EXEC, `ST_INTR` with `int_taken`=`pcWrite`=1, then FETCH. `intr_pend`=0 afterwards.
- Masked interrupt:
  - Stimulus: `intr` pulse with `mie`=0 for 3 instructions, then `mie`=1.
  - Required: no `int_taken` while masked; `int_taken` at the first boundary after `mie`=1.
- MRET, CSRRW and reset mid-operation:
  - SYS func3=000 required: `mret_exec`=1.
  - SYS func3=001 required: `csr_WE`=`regWrite`=1.
  - `RST` in `ST_WB` required: next state INIT with no `regWrite`.
